// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: producer/consumer handshake bundle for alu_result_buffer
// out_parity exists only when ALU_PARITY_FLAG_EN is defined.
interface alu_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_zero;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef ALU_PARITY_FLAG_EN
  logic                       out_parity;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_parity, count
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_parity, count
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, count
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, count
  );
`endif
endinterface

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: in-order FIFO capturing ALU results with per-entry zero flag
// Optional per-entry parity flag enabled by defining ALU_PARITY_FLAG_EN.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_result_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] zero_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;
  assign bus.in_ready  = count_q < CW'(DEPTH);
  assign bus.out_valid = count_q != '0;
  assign bus.out_data  = data_q[rd_ptr_q];
  assign bus.out_zero  = zero_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  // Slot 0 is reset so the idle head reads as data=0, zero=1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      zero_q <= '1;
    end else if (push && !flush) begin
      data_q[wr_ptr_q] <= bus.in_data;
      zero_q[wr_ptr_q] <= bus.in_data == '0;
    end
`ifdef ALU_PARITY_FLAG_EN
  logic [DEPTH-1:0] parity_q;
  assign bus.out_parity = parity_q[rd_ptr_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity_q <= '0;
    else if (push && !flush) parity_q[wr_ptr_q] <= ^bus.in_data;
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed + random checks against a queue-based reference model
module tb_alu_result_buffer;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int compared = 0;
  int mism = 0;
  logic [31:0] q [$];
  alu_result_buffer_if #(.WIDTH(32), .DEPTH(DEPTH)) bus ();
  alu_result_buffer #(.WIDTH(32), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  always #5 clk = ~clk;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check(string tag);
    cmp({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() < DEPTH));
    cmp({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    cmp({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    if (q.size() != 0) begin
      cmp({tag, ".out_data"}, bus.out_data, q[0]);
      cmp({tag, ".out_zero"}, 32'(bus.out_zero), 32'(q[0] == 0));
`ifdef ALU_PARITY_FLAG_EN
      cmp({tag, ".out_parity"}, 32'(bus.out_parity), 32'(^q[0]));
`endif
    end
  endtask

  // Drive one cycle at negedge, advance the model at the edge, check at next negedge
  task automatic cyc(string tag, logic iv, logic [31:0] d, logic ord, logic fl);
    bit p, o;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ord;
    flush = fl;
    p = iv && (q.size() < DEPTH);
    o = ord && (q.size() != 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (o) void'(q.pop_front());
      if (p) q.push_back(d);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    check(tag);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    cmp("reset.out_data", bus.out_data, 32'h0);
    cmp("reset.out_zero", 32'(bus.out_zero), 32'h1);
`ifdef ALU_PARITY_FLAG_EN
    cmp("reset.out_parity", 32'(bus.out_parity), 32'h0);
`endif
    check("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("release");
    // single entry
    cyc("single.push", 1, 32'hFFFF_FFFF, 0, 0);
    cyc("single.pop", 0, 32'h0, 1, 0);
    // fill, ignored third push, drain in order
    cyc("fill.p0", 1, 32'h0, 0, 0);
    cyc("fill.p1", 1, 32'h5555_5555, 0, 0);
    cyc("fill.p2", 1, 32'h1234_5678, 0, 0);
    cyc("fill.d0", 0, 32'h0, 1, 0);
    cyc("fill.d1", 0, 32'h0, 1, 0);
    cyc("fill.empty_pop", 0, 32'h0, 1, 0);
    // stream with continuous handshake on both sides
    for (int i = 0; i < 8; i++) begin
      cyc("stream", 1, 32'h1111_1111 * (i + 1), 1, 0);
      cmp("stream.count1", 32'(bus.count), 32'h1);
    end
    cyc("stream.drain", 0, 32'h0, 1, 0);
    // flush beats a same-cycle push
    cyc("flush.p0", 1, 32'hDEAD_BEEF, 0, 0);
    cyc("flush.p1", 1, 32'hCAFE_F00D, 0, 0);
    cyc("flush.cyc", 1, 32'h0BAD_0BAD, 1, 1);
    cmp("flush.count0", 32'(bus.count), 32'h0);
    cyc("flush.after", 1, 32'hAAAA_AAAA, 0, 0);
    cyc("flush.drain", 0, 32'h0, 1, 0);
    // parity flags
    cyc("par.p1", 1, 32'h0000_0001, 0, 0);
    cyc("par.p3", 1, 32'h0000_0003, 1, 0);
    // asynchronous reset mid-fill takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1 q.delete();
    cmp("areset.count", 32'(bus.count), 32'h0);
    cmp("areset.out_valid", 32'(bus.out_valid), 32'h0);
    cmp("areset.out_data", bus.out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc("areset.push", 1, 32'h0000_0007, 0, 0);
    cyc("areset.pop", 0, 32'h0, 1, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(3) == 0) ? 32'h0 : 32'($urandom);
      cyc("rand", 1'($urandom_range(1)), d, 1'($urandom_range(1)), $urandom_range(31) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
